clb_ecb_ctrl: RTL and testbench
===============================

Name: clb_ecb_ctrl

Overview:
- Stream controller directly upstream/downstream of the uLBC-128 ECB round core; the core itself stays a separate instance.
- Accepts 128-bit plaintext blocks plus key over a valid/ready handshake and buffers one block ahead.
- Drives the core's active-low load/reset and its textin/key inputs, waits for the core's done strobe, then captures the ciphertext into an output register with valid/ready.
- Turns the free-running core into a back-pressured block pipe with a watchdog.

Parameters:
- ROUNDS, 24, core round count; the core's done strobe is expected exactly ROUNDS cycles after load release.
- TMO_SLACK, 4, extra cycles tolerated past ROUNDS before the watchdog fires.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  input buffer empty, can accept.
- in_block  in  128  plaintext block.
- in_key  in  128  key, captured together with in_block.
- core_rst_n  out  1  registered active-low load/reset to the core.
- core_textin  out  128  buffered block driven to the core.
- core_key  out  128  buffered key driven to the core.
- core_textout  in  128  core result, valid only while core_enable=1.
- core_enable  in  1  core done strobe, held high once rounds complete.
- out_valid  out  1  ciphertext register full.
- out_ready  in  1  downstream accepts.
- out_block  out  128  ciphertext.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky watchdog error.
- blk_cnt  out  CNT_W  completed blocks, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: in_ready=1, core_rst_n=0 (core held), out_valid=0, out_block=0, busy=0, err=0, blk_cnt=0, buffers cleared, FSM=IDLE.
- Reset mid-operation drops all in-flight and buffered blocks.
- Input buffer (1 entry, block+key):
  - Fills on in_valid&in_ready; in_ready=!buf_full.
  - Frees at the edge the FSM leaves LOAD.
  - Fill and free on the same edge: net full, new data retained.
- core_textin/core_key are driven from a separate core-operand register, copied from the buffer on entry to LOAD. They stay stable through RUN/HOLD, so the buffer may prefetch the next block.
- FSM:
  - IDLE: core_rst_n=0. buf_full -> LOAD.
  - LOAD (1 cycle): core_rst_n=0, operands loaded, buffer freed -> RUN.
  - RUN: core_rst_n=1, watchdog counts from 0.
    - core_enable=1 and (!out_valid or out_ready): capture core_textout to out_block, set out_valid, blk_cnt+1. Then -> LOAD if buf_full (including a block accepted this edge), else IDLE.
    - core_enable=1 and output blocked: -> HOLD.
    - Watchdog reaches ROUNDS+TMO_SLACK without core_enable: set err, discard block, -> IDLE.
  - HOLD: core_rst_n=1, core parked at done. Capture on the first edge where out_valid=0 or out_ready=1; exits as from RUN.
- Output register: out_valid clears on out_valid&out_ready unless a capture happens on the same edge (then stays 1 with new data).
- Latency (empty pipe, out_ready=1):
  - Block accepted at edge E0; LOAD after E0; core_rst_n rises after E1; core_enable high after E1+ROUNDS.
  - Capture at E2+ROUNDS, so out_valid is high in the cycle after edge E26 (26 edges for ROUNDS=24).
  - Throughput with prefetch: one block per ROUNDS+2 cycles.
- err clears only on rst; after an error the block continues to process new blocks.

Decomposition:
- Package clb_pkg: BLK_W=128, KEY_W=128, ROUNDS=24, FSM state enum {IDLE, LOAD, RUN, HOLD}.
- One natural sub-module: clb_blk_buf, a 1-entry valid/ready register, reused for the input buffer. The output register is built inline because of its capture/drain rule.
- The core itself is instantiated at the level above.

Test Plan:
- Known-answer: reset, send block 0x0123…cdef with key 0x0011…ff; the core model raises enable 24 cycles after release -> out_valid rises 26 edges after acceptance, out_block equals core_textout, blk_cnt=1.
- Back-to-back: offer 4 blocks with in_valid held high -> in_ready low while the buffer is full; outputs every 26 cycles in order; blk_cnt=4.
- Back-pressure: out_ready=0 for 60 cycles with 2 blocks sent -> FSM in HOLD, core_rst_n stays 1, first result held stable; on release both results emerge in order with no loss.
- Watchdog: core_enable stuck 0 -> err=1 at ROUNDS+TMO_SLACK cycles after release, FSM returns to IDLE, the next good block still completes.
- Reset mid-RUN: assert rst 10 cycles into RUN -> all outputs at reset values immediately; no stale out_valid after release.
- Counter wrap: with CNT_W=2, run 5 blocks -> blk_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/clb_pkg.sv
// Shared widths, FSM encodings and the operand record for the uLBC-128 ECB stream controller.
package clb_pkg;
  localparam int BLK_W  = 128;
  localparam int KEY_W  = 128;
  localparam int ROUNDS = 24;

  typedef logic [1:0] clb_state_t;
  localparam clb_state_t ST_IDLE = 2'd0;
  localparam clb_state_t ST_LOAD = 2'd1;
  localparam clb_state_t ST_RUN  = 2'd2;
  localparam clb_state_t ST_HOLD = 2'd3;

  typedef struct packed {
    logic [BLK_W-1:0] block;
    logic [KEY_W-1:0] key;
  } clb_op_t;
endpackage

// File: rtl/clb_blk_buf.sv
// One-entry valid/ready holding register; a pop and a fill on the same edge keep the new data.
module clb_blk_buf #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  input  logic         rd_pop
);
  logic fill;

  assign wr_ready = !rd_valid;
  assign fill     = wr_valid && wr_ready;

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      // NOTE: the data register is reset too, so a cleared buffer never exposes a stale block.
      rd_data  <= '0;
    end else begin
      rd_valid <= fill || (rd_valid && !rd_pop);
      if (fill) rd_data <= wr_data;
    end
  end
endmodule

// File: rtl/clb_ecb_ctrl.sv
// Stream controller around the uLBC-128 ECB core: input prefetch buffer, core load/run
// sequencing with a done-strobe watchdog, and a back-pressured ciphertext register.
module clb_ecb_ctrl
  import clb_pkg::*;
#(
  parameter int ROUNDS    = clb_pkg::ROUNDS,
  parameter int TMO_SLACK = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  input  logic [KEY_W-1:0] in_key,
  output logic             core_rst_n,
  output logic [BLK_W-1:0] core_textin,
  output logic [KEY_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_textout,
  input  logic             core_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);
  localparam int WD_LIM = ROUNDS + TMO_SLACK;
  localparam int WD_W   = $clog2(WD_LIM + 1);

  clb_state_t      st, st_nxt;
  clb_op_t         in_op, buf_q, op_q;
  logic            buf_full, buf_pop, in_fire, next_ready, capture, wd_fire;
  logic [WD_W-1:0] wd;

  assign in_op = '{block: in_block, key: in_key};

  clb_blk_buf #(.W($bits(clb_op_t))) u_in_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (in_op),
    .rd_valid (buf_full),
    .rd_data  (buf_q),
    .rd_pop   (buf_pop)
  );

  assign in_fire    = in_valid && in_ready;
  assign buf_pop    = (st == ST_LOAD);
  // A block arriving on this very edge counts as a waiting block.
  assign next_ready = buf_full || in_fire;
  assign capture    = core_enable && (st == ST_RUN || st == ST_HOLD) && (!out_valid || out_ready);
  assign wd_fire    = (st == ST_RUN) && !core_enable && (wd == WD_W'(WD_LIM - 1));

  // NOTE: st_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (next_ready) st_nxt = ST_LOAD;
      ST_LOAD: st_nxt = ST_RUN;
      default: begin
        if (capture)          st_nxt = next_ready ? ST_LOAD : ST_IDLE;
        else if (core_enable) st_nxt = ST_HOLD;
        else if (wd_fire)     st_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      wd         <= '0;
      core_rst_n <= 1'b0;
      op_q       <= '0;
      out_valid  <= 1'b0;
      out_block  <= '0;
      err        <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      st         <= st_nxt;
      core_rst_n <= (st_nxt == ST_RUN) || (st_nxt == ST_HOLD);
      wd         <= (st == ST_RUN && st_nxt == ST_RUN) ? wd + WD_W'(1) : '0;
      // Operands are latched on entry to LOAD and stay put while the buffer prefetches.
      if (st_nxt == ST_LOAD && st != ST_LOAD) op_q <= buf_full ? buf_q : in_op;
      if (capture) begin
        out_valid <= 1'b1;
        out_block <= core_textout;
        blk_cnt   <= blk_cnt + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wd_fire) err <= 1'b1;
    end
  end

  assign core_textin = op_q.block;
  assign core_key    = op_q.key;
  assign busy        = (st != ST_IDLE);
endmodule

// File: tb/tb_clb_ecb_ctrl.sv
// Self-checking bench for clb_ecb_ctrl: core model, ordered ciphertext scoreboard and directed tests.
module tb_clb_ecb_ctrl;
  localparam int ROUNDS    = 24;
  localparam int TMO_SLACK = 4;
  localparam int CNT_W     = 16;
  localparam logic [127:0] KA_BLK = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] KA_KEY = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KA_CT  = 128'h89baefdc4576231001326754cdfeab98;
  localparam logic [127:0] BP_A   = 128'haaaa5555aaaa5555aaaa5555aaaa5555;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [127:0] in_block = '0, in_key = '0;
  logic in_ready, core_rst_n, out_valid, busy, err, core_enable;
  logic [127:0] core_textin, core_key, core_textout, out_block;
  logic [CNT_W-1:0] blk_cnt;
  logic in_ready_w2, core_rst_n_w2, out_valid_w2, busy_w2, err_w2;
  logic [127:0] core_textin_w2, core_key_w2, out_block_w2;
  logic [1:0] blk_cnt_w2;

  int checks = 0, failures = 0, cyc = 0, core_cnt = 0, delivered = 0;
  logic core_stuck = 1'b0, exp_err = 1'b0, pend_hs = 1'b0, prev_valid = 1'b0;
  logic [127:0] exp_q[$];
  int t_q[$];
  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] enc(input logic [127:0] b, input logic [127:0] k);
    return b ^ {k[63:0], k[127:64]};
  endfunction

  // Core model: done strobe ROUNDS edges after release, garbage on textout before that.
  always @(posedge clk) begin
    if (!core_rst_n) core_cnt <= 0;
    else if (core_cnt < ROUNDS) core_cnt <= core_cnt + 1;
  end
  assign core_enable  = (core_cnt == ROUNDS) && !core_stuck;
  assign core_textout = core_enable ? enc(core_textin, core_key) : {4{32'hdeadbeef}};

  clb_ecb_ctrl #(.ROUNDS(ROUNDS), .TMO_SLACK(TMO_SLACK), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_key(in_key), .core_rst_n(core_rst_n), .core_textin(core_textin), .core_key(core_key),
    .core_textout(core_textout), .core_enable(core_enable), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy), .err(err), .blk_cnt(blk_cnt));

  clb_ecb_ctrl #(.ROUNDS(ROUNDS), .TMO_SLACK(TMO_SLACK), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w2), .in_block(in_block),
    .in_key(in_key), .core_rst_n(core_rst_n_w2), .core_textin(core_textin_w2),
    .core_key(core_key_w2), .core_textout(core_textout), .core_enable(core_enable),
    .out_valid(out_valid_w2), .out_ready(out_ready), .out_block(out_block_w2),
    .busy(busy_w2), .err(err_w2), .blk_cnt(blk_cnt_w2));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the ordered scoreboard and the counter/err rules.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend_hs    = 1'b0;
      prev_valid = 1'b0;
      delivered  = 0;
    end else begin
      if (pend_hs) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        delivered++;
      end
      if (prev_valid && !pend_hs) checkb("out_hold", out_valid, 1'b1);
      if (out_valid) begin
        if (!prev_valid || pend_hs) t_q.push_back(cyc);
        if (exp_q.size() == 0) checkb("out_unexpected", out_valid, 1'b0);
        else check("out_block", out_block, exp_q[0]);
      end
      checki("blk_cnt", int'(blk_cnt), (delivered + int'(out_valid)) % 65536);
      checki("blk_cnt_w2", int'(blk_cnt_w2), (delivered + int'(out_valid)) % 4);
      checkb("err", err, exp_err);
      checki("w2_ctrl", int'({in_ready_w2, core_rst_n_w2, out_valid_w2, busy_w2, err_w2}),
             int'({in_ready, core_rst_n, out_valid, busy, err}));
      check("w2_block", out_block_w2, out_block);
      check("w2_textin", core_textin_w2, core_textin);
      check("w2_key", core_key_w2, core_key);
      pend_hs    = out_valid && out_ready;
      prev_valid = out_valid;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    exp_err = 1'b0;
    exp_q.delete();
    t_q.delete();
    #1;
    checkb("rst_in_ready", in_ready, 1'b1);
    checkb("rst_core_rst_n", core_rst_n, 1'b0);
    checkb("rst_out_valid", out_valid, 1'b0);
    check("rst_out_block", out_block, '0);
    check("rst_textin", core_textin, '0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_err", err, 1'b0);
    checki("rst_blk_cnt", int'(blk_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [127:0] b, input logic [127:0] k, input bit track,
                      output int acc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_block = b;
    in_key   = k;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkb("in_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (track) exp_q.push_back(enc(b, k));
  endtask

  task automatic drop_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_item(output int t);
    int n = 0;
    while (t_q.size() == 0 && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkb("out_arrives", t_q.size() != 0, 1'b1);
    t = (t_q.size() != 0) ? t_q.pop_front() : -1;
  endtask

  initial begin
    #400000;
    checks++;
    failures++;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int acc, t;
    int accs[4];
    apply_reset();

    // Known answer and empty-pipe latency.
    send(KA_BLK, KA_KEY, 1'b1, acc);
    drop_in();
    repeat (5) @(negedge clk);
    #1;
    check("ka_textin", core_textin, KA_BLK);
    check("ka_key", core_key, KA_KEY);
    checkb("ka_release", core_rst_n, 1'b1);
    checkb("ka_busy", busy, 1'b1);
    wait_item(t);
    checki("ka_latency", t - acc, 26);
    check("ka_block", out_block, KA_CT);
    checki("ka_cnt", int'(blk_cnt), 1);

    // Back-to-back with in_valid held high.
    apply_reset();
    for (int i = 0; i < 4; i++)
      send({32'(i), 96'h1234_5678_9abc_def0_1357_9bdf}, {96'h0, 32'(i * 7 + 3)}, 1'b1, accs[i]);
    drop_in();
    checki("b2b_acc1", accs[1] - accs[0], 2);
    checki("b2b_acc2", accs[2] - accs[1], 26);
    checki("b2b_acc3", accs[3] - accs[2], 26);
    for (int i = 0; i < 4; i++) begin
      wait_item(t);
      checki("b2b_out_time", t - accs[0], 26 * (i + 1));
    end
    checki("b2b_cnt", int'(blk_cnt), 4);

    // Back-pressure: both results parked, then drained in order.
    apply_reset();
    @(negedge clk);
    out_ready = 1'b0;
    send(BP_A, '0, 1'b1, acc);
    send(~BP_A, 128'h5, 1'b1, acc);
    drop_in();
    repeat (60) @(negedge clk);
    #1;
    checkb("bp_busy", busy, 1'b1);
    checkb("bp_core_held", core_rst_n, 1'b1);
    checkb("bp_valid", out_valid, 1'b1);
    check("bp_first", out_block, BP_A);
    checkb("bp_in_ready", in_ready, 1'b1);
    checki("bp_cnt", int'(blk_cnt), 1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_item(t);
    wait_item(t);
    repeat (5) @(negedge clk);
    #1;
    checki("bp_drained", exp_q.size(), 0);
    checki("bp_cnt_done", int'(blk_cnt), 2);
    checkb("bp_idle", busy, 1'b0);

    // Watchdog: done strobe never arrives.
    core_stuck = 1'b1;
    send(128'hfeed, 128'hbeef, 1'b0, acc);
    drop_in();
    repeat (ROUNDS + TMO_SLACK) @(posedge clk);
    #1;
    checkb("wd_err_early", err, 1'b0);
    @(posedge clk);
    #1;
    checkb("wd_err", err, 1'b1);
    checkb("wd_idle", busy, 1'b0);
    checkb("wd_core_held", core_rst_n, 1'b0);
    exp_err = 1'b1;
    @(negedge clk);
    core_stuck = 1'b0;
    send(128'hc0ffee, 128'h77, 1'b1, acc);
    drop_in();
    wait_item(t);
    checki("wd_recover_lat", t - acc, 26);
    checki("wd_recover_cnt", int'(blk_cnt), 3);

    // Reset while the second block is mid-RUN and the first is parked in the output.
    @(negedge clk);
    out_ready = 1'b0;
    send(128'h11, 128'h22, 1'b1, acc);
    send(128'h33, 128'h44, 1'b1, acc);
    drop_in();
    wait_item(t);
    repeat (10) @(negedge clk);
    #1;
    checkb("mid_busy", busy, 1'b1);
    checkb("mid_release", core_rst_n, 1'b1);
    checkb("mid_valid", out_valid, 1'b1);
    apply_reset();
    @(negedge clk);
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    checkb("rst_no_stale", out_valid, 1'b0);
    checkb("rst_stay_idle", busy, 1'b0);

    // Counter wrap on the CNT_W=2 instance.
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      send(128'(k * 3 + 1), 128'(k), 1'b1, acc);
      drop_in();
      wait_item(t);
      checki("wrap_cnt", int'(blk_cnt_w2), wrap_exp[k]);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
